// File: rtl/ray_gen_scheduler_pkg.sv
// Shared types for the ray generation scheduler: fixed-point vec3, FSM states, pixel tags.
// Raster geometry defaults come from DISPLAY_WIDTH/DISPLAY_HEIGHT/H_BITS/V_BITS macros.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

package ray_gen_scheduler_pkg;
  localparam int unsigned FP_W = 16;

  typedef logic signed [FP_W-1:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  localparam int unsigned VEC3_W = $bits(vec3_t);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [`H_BITS-1:0] hcount;
    logic [`V_BITS-1:0] vcount;
  } pixel_tag_t;
endpackage

// File: rtl/ray_gen_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);
  logic [IW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IW'((32'(ptr) + off) % N);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ray_gen_scheduler.sv
// Frame-level scheduler: scans the raster, dispatches pixels to ray-generator units
// round-robin, and drains tagged results. Optional RAY_GEN_SCHED_STATS_EN adds cycle counters.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_gen_scheduler
  import ray_gen_scheduler_pkg::*;
#(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int unsigned DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int unsigned H_BITS         = `H_BITS,
  parameter int unsigned V_BITS         = `V_BITS
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  vec3_t                         cam_forward_in,
  output logic                          busy_out,
  output logic                          frame_done_out,
  output logic [NUM_UNITS-1:0]          gen_valid_out,
  output logic [H_BITS-1:0]             gen_hcount_out,
  output logic [V_BITS-1:0]             gen_vcount_out,
  output vec3_t                         gen_cam_forward_out,
  input  logic [NUM_UNITS-1:0]          gen_ready_in,
  input  logic [NUM_UNITS-1:0]          gen_valid_in,
  input  logic [NUM_UNITS*VEC3_W-1:0]   gen_ray_in,
  output logic                          ray_valid_out,
  input  logic                          ray_ready_in,
  output vec3_t                         ray_direction_out,
  output logic [H_BITS-1:0]             ray_hcount_out,
  output logic [V_BITS-1:0]             ray_vcount_out
`ifdef RAY_GEN_SCHED_STATS_EN
  ,
  output logic [31:0]                   stall_cycles_out,
  output logic [31:0]                   frame_cycles_out
`endif
);
  localparam int unsigned PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  state_t               state, state_next;
  logic [H_BITS-1:0]    hcount;
  logic [V_BITS-1:0]    vcount;
  logic [NUM_UNITS-1:0] busy, slot_full, eligible, disp_grant, out_grant, out_clear;
  logic [PW-1:0]        dispatch_ptr, out_ptr, disp_idx, out_idx;
  logic                 disp_any, out_any;
  logic                 scan, drain, start_accept, dispatch, last_pixel, handshake, frame_end;
  pixel_tag_t           unit_tag [NUM_UNITS];
  pixel_tag_t           slot_tag [NUM_UNITS];
  vec3_t                slot_ray [NUM_UNITS];

  assign eligible   = gen_ready_in & ~busy & ~slot_full;
  assign dispatch   = scan && disp_any;
  assign last_pixel = (hcount == H_BITS'(DISPLAY_WIDTH - 1)) && (vcount == V_BITS'(DISPLAY_HEIGHT - 1));
  assign ray_valid_out = |slot_full;
  assign handshake  = ray_valid_out && ray_ready_in;
  assign out_clear  = handshake ? out_grant : '0;
  // Frame ends once no unit is in flight and the slots will be empty after this edge.
  assign frame_end  = drain && (busy == '0) && ((slot_full & ~out_clear) == '0);

  rr_arbiter #(.N(NUM_UNITS), .IW(PW)) u_dispatch_arb (
    .req(eligible), .ptr(dispatch_ptr),
    .grant(disp_grant), .grant_idx(disp_idx), .grant_valid(disp_any)
  );

  rr_arbiter #(.N(NUM_UNITS), .IW(PW)) u_output_arb (
    .req(slot_full), .ptr(out_ptr),
    .grant(out_grant), .grant_idx(out_idx), .grant_valid(out_any)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_in) state_next = SCAN;
      SCAN:    if (dispatch && last_pixel) state_next = DRAIN;
      DRAIN:   if (frame_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_out     = (state != IDLE);
    scan         = (state == SCAN);
    drain        = (state == DRAIN);
    start_accept = (state == IDLE) && start_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_done_out      <= 1'b0;
      gen_valid_out       <= '0;
      gen_hcount_out      <= '0;
      gen_vcount_out      <= '0;
      gen_cam_forward_out <= '0;
      hcount              <= '0;
      vcount              <= '0;
      busy                <= '0;
      slot_full           <= '0;
      dispatch_ptr        <= '0;
      out_ptr             <= '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        unit_tag[i] <= '0;
        slot_tag[i] <= '0;
        slot_ray[i] <= '0;
      end
    end else begin
      frame_done_out <= frame_end;
      gen_valid_out  <= dispatch ? disp_grant : '0;
      if (start_accept) begin
        gen_cam_forward_out <= cam_forward_in;
        hcount              <= '0;
        vcount              <= '0;
      end
      if (dispatch) begin
        gen_hcount_out     <= hcount;
        gen_vcount_out     <= vcount;
        unit_tag[disp_idx] <= '{hcount: hcount, vcount: vcount};
        dispatch_ptr       <= PW'((32'(disp_idx) + 1) % NUM_UNITS);
        if (hcount == H_BITS'(DISPLAY_WIDTH - 1)) begin
          hcount <= '0;
          vcount <= vcount + V_BITS'(1);
        end else begin
          hcount <= hcount + H_BITS'(1);
        end
      end
      if (handshake) out_ptr <= PW'((32'(out_idx) + 1) % NUM_UNITS);
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        if (dispatch && disp_grant[i]) busy[i] <= 1'b1;
        if (out_clear[i]) slot_full[i] <= 1'b0;
        if (gen_valid_in[i]) begin
          slot_ray[i]  <= gen_ray_in[i*VEC3_W +: VEC3_W];
          slot_tag[i]  <= unit_tag[i];
          slot_full[i] <= 1'b1;
          busy[i]      <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ray_direction_out = '0;
    ray_hcount_out    = '0;
    ray_vcount_out    = '0;
    if (out_any) begin
      ray_direction_out = slot_ray[out_idx];
      ray_hcount_out    = slot_tag[out_idx].hcount;
      ray_vcount_out    = slot_tag[out_idx].vcount;
    end
  end

  capture_into_full_slot: assert property (@(posedge clk_in) disable iff (rst_in)
    (gen_valid_in & slot_full) == '0);

`ifdef RAY_GEN_SCHED_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cycles_out <= '0;
      frame_cycles_out <= '0;
    end else if (start_accept) begin
      stall_cycles_out <= '0;
      frame_cycles_out <= '0;
    end else begin
      if (scan && (eligible == '0)) stall_cycles_out <= stall_cycles_out + 32'd1;
      if (busy_out) frame_cycles_out <= frame_cycles_out + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ray_gen_scheduler.sv
// Self-checking bench for ray_gen_scheduler with a behavioural ray-generator unit model.
module tb_ray_gen_scheduler;
  import ray_gen_scheduler_pkg::*;

  localparam int unsigned NU   = 4;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 3;
  localparam int unsigned HB   = 9;
  localparam int unsigned VB   = 8;
  localparam int unsigned NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ray_ready = 1'b0;
  vec3_t cam_in = '0;
  logic busy, frame_done, ray_valid;
  logic [NU-1:0] gen_valid;
  logic [NU-1:0] gen_ready = '0;
  logic [NU-1:0] gen_done = '0;
  logic [NU*VEC3_W-1:0] gen_ray = '0;
  logic [HB-1:0] gen_h, ray_h;
  logic [VB-1:0] gen_v, ray_v;
  vec3_t gen_cam, ray_dir;
`ifdef RAY_GEN_SCHED_STATS_EN
  logic [31:0] stall_cycles, frame_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [NU-1:0] unit_en = '1;
  int    lat_fixed [NU];
  bit    u_busy [NU];
  int    u_cnt [NU];
  int    u_h [NU];
  int    u_v [NU];
  vec3_t u_cam [NU];
  int    protocol_bad = 0;
  int    done_cnt = 0;
  int    done_busy_bad = 0;
  int    d_unit[$], d_h[$], d_v[$], d_cyc[$];
  int    out_h[$], out_v[$], out_cyc[$];
  vec3_t out_d[$];

  ray_gen_scheduler #(
    .NUM_UNITS(NU), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .cam_forward_in(cam_in),
    .busy_out(busy), .frame_done_out(frame_done),
    .gen_valid_out(gen_valid), .gen_hcount_out(gen_h), .gen_vcount_out(gen_v),
    .gen_cam_forward_out(gen_cam), .gen_ready_in(gen_ready), .gen_valid_in(gen_done),
    .gen_ray_in(gen_ray), .ray_valid_out(ray_valid), .ray_ready_in(ray_ready),
    .ray_direction_out(ray_dir), .ray_hcount_out(ray_h), .ray_vcount_out(ray_v)
`ifdef RAY_GEN_SCHED_STATS_EN
    , .stall_cycles_out(stall_cycles), .frame_cycles_out(frame_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic vec3_t ray_of(int h, int v, vec3_t c);
    vec3_t r;
    r.x = fp_t'(int'(c.x) + h * 7 + v + 1);
    r.y = fp_t'(int'(c.y) + v * 11 + 3);
    r.z = fp_t'(int'(c.z) ^ (h * 64 + v));
    return r;
  endfunction

  function automatic vec3_t rand_vec();
    vec3_t r;
    r.x = fp_t'($urandom);
    r.y = fp_t'($urandom);
    r.z = fp_t'($urandom);
    return r;
  endfunction

  // Every pixel must come out exactly once, with the ray its coordinates imply.
  function automatic int frame_errors(vec3_t c);
    int cnt [NPIX];
    int bad = 0;
    foreach (cnt[p]) cnt[p] = 0;
    if (out_h.size() != NPIX) bad++;
    foreach (out_h[k]) begin
      if (out_h[k] >= W || out_v[k] >= H) bad++;
      else begin
        cnt[out_v[k] * W + out_h[k]]++;
        if (out_d[k] !== ray_of(out_h[k], out_v[k], c)) bad++;
      end
    end
    foreach (cnt[p]) if (cnt[p] != 1) bad++;
    return bad;
  endfunction

  // Unit model: drops ready on dispatch, returns a one-cycle result after its latency.
  always @(negedge clk) begin
    if (rst) begin
      gen_done = '0;
      gen_ready = '0;
      for (int i = 0; i < NU; i++) u_busy[i] = 1'b0;
    end else begin
      if ($countones(gen_valid) > 1) protocol_bad++;
      for (int i = 0; i < NU; i++) begin
        bit was_busy;
        was_busy = u_busy[i];
        if (gen_done[i]) gen_done[i] = 1'b0;
        if (u_busy[i]) begin
          if (u_cnt[i] == 0) begin
            gen_done[i] = 1'b1;
            gen_ray[i*VEC3_W +: VEC3_W] = ray_of(u_h[i], u_v[i], u_cam[i]);
            u_busy[i] = 1'b0;
          end else begin
            u_cnt[i]--;
          end
        end
        gen_ready[i] = unit_en[i] && !u_busy[i] && !gen_done[i];
        if (gen_valid[i]) begin
          if (was_busy || !unit_en[i]) protocol_bad++;
          u_busy[i] = 1'b1;
          u_cnt[i]  = (lat_fixed[i] != 0) ? lat_fixed[i] - 1 : int'($urandom_range(0, 11));
          u_h[i]    = int'(gen_h);
          u_v[i]    = int'(gen_v);
          u_cam[i]  = gen_cam;
          gen_ready[i] = 1'b0;
          d_unit.push_back(i);
          d_h.push_back(int'(gen_h));
          d_v.push_back(int'(gen_v));
          d_cyc.push_back(cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ray_valid && ray_ready) begin
        out_h.push_back(int'(ray_h));
        out_v.push_back(int'(ray_v));
        out_d.push_back(ray_dir);
        out_cyc.push_back(cyc);
      end
      if (frame_done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_logs();
    d_unit.delete(); d_h.delete(); d_v.delete(); d_cyc.delete();
    out_h.delete(); out_v.delete(); out_d.delete(); out_cyc.delete();
    done_cnt = 0;
    done_busy_bad = 0;
    protocol_bad = 0;
  endtask

  task automatic start_frame(input vec3_t c);
    @(posedge clk); #1;
    cam_in = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (rnd) ray_ready = 1'($urandom_range(0, 1));
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
    end
    ray_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, frame_done, ray_valid} !== 3'b000)
      begin errors++; $display("FAIL reset_flags: busy/done/valid=%b expected 000", {busy, frame_done, ray_valid}); end
    checks++;
    if (gen_valid !== '0) begin errors++; $display("FAIL reset_gen_valid: %b expected 0", gen_valid); end
    checks++;
    if ({gen_h, gen_v, gen_cam} !== '0)
      begin errors++; $display("FAIL reset_gen_bus: %h expected 0", {gen_h, gen_v, gen_cam}); end
    checks++;
    if ({ray_dir, ray_h, ray_v} !== '0)
      begin errors++; $display("FAIL reset_ray_bus: %h expected 0", {ray_dir, ray_h, ray_v}); end
    rst = 1'b0;
  endtask

  task automatic test_first_dispatch();
    vec3_t cam;
    bit ok;
    int bad;
    do_reset();
    unit_en = '1;
    foreach (lat_fixed[i]) lat_fixed[i] = 10;
    ray_ready = 1'b1;
    clear_logs();
    cam = rand_vec();
    @(posedge clk); #1;
    cam_in = cam;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (gen_valid !== '0) begin errors++; $display("FAIL latency_early: gen_valid_out=%b expected 0", gen_valid); end
    @(posedge clk); #1;
    checks++;
    if (gen_valid !== NU'(1)) begin errors++; $display("FAIL latency_first: gen_valid_out=%b expected 0001", gen_valid); end
    checks++;
    if (gen_cam !== cam) begin errors++; $display("FAIL cam_latch: %h expected %h", gen_cam, cam); end
    cam_in = vec3_t'(~cam);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (gen_cam !== cam) begin errors++; $display("FAIL start_ignored: cam %h expected %h", gen_cam, cam); end
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL first_timeout: frame_done seen=%0d expected 1", ok); end
    bad = 0;
    for (int k = 0; k < 4; k++)
      if (d_unit.size() <= k || d_unit[k] != k || d_h[k] != k || d_v[k] != 0 || d_cyc[k] != d_cyc[0] + k) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL first_order: %0d bad of first 4 dispatches, expected 0", bad); end
    checks++;
    bad = frame_errors(cam);
    if (bad !== 0) begin errors++; $display("FAIL first_frame: %0d bad results, expected 0", bad); end
    checks++;
    if (done_cnt !== 1 || done_busy_bad !== 0 || protocol_bad !== 0)
      begin errors++; $display("FAIL first_done: done=%0d busy_at_done=%0d proto=%0d expected 1/0/0", done_cnt, done_busy_bad, protocol_bad); end
  endtask

  task automatic test_partial_ready();
    vec3_t cam;
    bit ok;
    int bad, stray;
    do_reset();
    unit_en = 4'b0101;
    foreach (lat_fixed[i]) lat_fixed[i] = 6;
    ray_ready = 1'b1;
    clear_logs();
    cam = rand_vec();
    start_frame(cam);
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL partial_timeout: frame_done seen=%0d expected 1", ok); end
    bad = 0;
    for (int k = 0; k < 4; k++)
      if (d_unit.size() <= k || d_unit[k] != ((k % 2) * 2)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL partial_alternate: %0d bad of first 4 grants, expected 0", bad); end
    stray = 0;
    foreach (d_unit[k]) if (d_unit[k] == 1 || d_unit[k] == 3) stray++;
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL partial_stray: %0d strobes to units 1/3, expected 0", stray); end
    checks++;
    bad = frame_errors(cam);
    if (bad !== 0) begin errors++; $display("FAIL partial_frame: %0d bad results, expected 0", bad); end
    unit_en = '1;
  endtask

  task automatic test_backpressure();
    vec3_t cam, dir0;
    bit ok;
    int unstable, bad;
    do_reset();
    unit_en = '1;
    foreach (lat_fixed[i]) lat_fixed[i] = 3;
    ray_ready = 1'b0;
    clear_logs();
    cam = rand_vec();
    start_frame(cam);
    repeat (20) @(posedge clk);
    #1;
    dir0 = ray_dir;
    unstable = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (ray_dir !== dir0 || ray_valid !== 1'b1) unstable++;
    end
    checks++;
    if (d_unit.size() !== NU) begin errors++; $display("FAIL bp_dispatches: %0d expected %0d", d_unit.size(), NU); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, expected 0", unstable); end
    checks++;
    if (dir0 !== ray_of(0, 0, cam)) begin errors++; $display("FAIL bp_held_ray: %h expected %h", dir0, ray_of(0, 0, cam)); end
    ray_ready = 1'b1;
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: frame_done seen=%0d expected 1", ok); end
    checks++;
    bad = frame_errors(cam);
    if (bad !== 0) begin errors++; $display("FAIL bp_frame: %0d bad results, expected 0", bad); end
  endtask

  task automatic test_simultaneous();
    vec3_t cam;
    bit ok;
    int bad;
    do_reset();
    unit_en = '1;
    lat_fixed[0] = 6;
    lat_fixed[1] = 5;
    lat_fixed[2] = 14;
    lat_fixed[3] = 14;
    ray_ready = 1'b1;
    clear_logs();
    cam = rand_vec();
    start_frame(cam);
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL simul_timeout: frame_done seen=%0d expected 1", ok); end
    checks++;
    if (out_h.size() < 2 || out_h[0] != 0 || out_v[0] != 0 || out_h[1] != 1 || out_v[1] != 0)
      begin errors++; $display("FAIL simul_order: first tags (%0d,%0d),(%0d,%0d) expected (0,0),(1,0)", out_h[0], out_v[0], out_h[1], out_v[1]); end
    checks++;
    if (out_cyc.size() < 2 || out_cyc[1] != out_cyc[0] + 1)
      begin errors++; $display("FAIL simul_consecutive: cycles %0d,%0d expected adjacent", out_cyc[0], out_cyc[1]); end
    checks++;
    bad = frame_errors(cam);
    if (bad !== 0) begin errors++; $display("FAIL simul_frame: %0d bad results, expected 0", bad); end
  endtask

  task automatic test_reset_mid_scan();
    vec3_t cam;
    bit ok;
    int bad;
    do_reset();
    unit_en = '1;
    foreach (lat_fixed[i]) lat_fixed[i] = 0;
    ray_ready = 1'b1;
    clear_logs();
    start_frame(rand_vec());
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: busy=%b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, frame_done, gen_valid, gen_h, gen_v, gen_cam, ray_valid, ray_dir, ray_h, ray_v} !== '0)
      begin errors++; $display("FAIL midrst_outputs: %h expected 0", {busy, frame_done, gen_valid, gen_h, gen_v, gen_cam, ray_valid, ray_dir, ray_h, ray_v}); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: frame_done pulses=%0d expected 0", done_cnt); end
    cam = rand_vec();
    start_frame(cam);
    wait_done(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: frame_done seen=%0d expected 1", ok); end
    checks++;
    if (d_unit.size() == 0 || d_unit[0] != 0 || d_h[0] != 0 || d_v[0] != 0)
      begin errors++; $display("FAIL midrst_restart: first unit=%0d tag (%0d,%0d) expected 0 (0,0)", d_unit[0], d_h[0], d_v[0]); end
    checks++;
    bad = frame_errors(cam);
    if (bad !== 0) begin errors++; $display("FAIL midrst_frame: %0d bad results, expected 0", bad); end
  endtask

  task automatic test_random_frames();
    vec3_t cam;
    bit ok;
    int bad;
    foreach (lat_fixed[i]) lat_fixed[i] = 0;
    for (int f = 0; f < 3; f++) begin
      unit_en = NU'($urandom_range(1, (1 << NU) - 1));
      clear_logs();
      cam = rand_vec();
      start_frame(cam);
      wait_done(1'b1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_timeout: frame %0d done seen=%0d expected 1", f, ok); end
      checks++;
      bad = frame_errors(cam);
      if (bad !== 0) begin errors++; $display("FAIL rand_frame: frame %0d has %0d bad results, expected 0", f, bad); end
      checks++;
      if (done_cnt !== 1 || done_busy_bad !== 0 || protocol_bad !== 0)
        begin errors++; $display("FAIL rand_done: frame %0d done=%0d busy_at_done=%0d proto=%0d expected 1/0/0", f, done_cnt, done_busy_bad, protocol_bad); end
    end
    unit_en = '1;
  endtask

  initial begin
    foreach (lat_fixed[i]) lat_fixed[i] = 0;
    test_reset();
    test_first_dispatch();
    test_partial_ready();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_scan();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ray_gen_scheduler.md
Name: ray_gen_scheduler

Overview:
- Sequences one frame of primary-ray generation across NUM_UNITS folded ray-generator instances, each with the ready/valid interface of the folded ray generator.
- Scans the raster, dispatches each pixel to a free unit using round-robin, and captures each result with its pixel coordinates into a per-unit slot.
- Drains the slots to the downstream marcher through a valid/ready stream.
- Sits between the frame controller and the ray-marching core.

Parameters:
- NUM_UNITS, 4, number of ray-generator instances managed (1..8).
- DISPLAY_WIDTH, `DISPLAY_WIDTH, pixels per line.
- DISPLAY_HEIGHT, `DISPLAY_HEIGHT, lines per frame.
- H_BITS, `H_BITS, width of hcount.
- V_BITS, `V_BITS, width of vcount.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- start_in  in  1  one-cycle pulse that begins a frame; ignored unless idle
- cam_forward_in  in  vec3  camera forward vector; latched at start
- busy_out  out  1  frame in progress
- frame_done_out  out  1  one-cycle pulse after the last pixel is accepted downstream
- gen_valid_out  out  NUM_UNITS  per-unit dispatch strobe, one-cycle pulse
- gen_hcount_out  out  H_BITS  broadcast pixel column
- gen_vcount_out  out  V_BITS  broadcast pixel row
- gen_cam_forward_out  out  vec3  broadcast latched forward vector
- gen_ready_in  in  NUM_UNITS  unit ready_out signals
- gen_valid_in  in  NUM_UNITS  unit valid_out signals; one-cycle result pulse
- gen_ray_in  in  NUM_UNITS*vec3  unit ray_direction_out signals, packed with unit 0 at the LSB
- ray_valid_out  out  1  result available downstream
- ray_ready_in  in  1  downstream accepts
- ray_direction_out  out  vec3  normalised ray direction
- ray_hcount_out  out  H_BITS  pixel column of the result
- ray_vcount_out  out  V_BITS  pixel row of the result

Behaviour:
- Reset (asynchronous): all outputs are 0, FSM is in IDLE, pixel counters are 0, busy and slot-full bits are cleared, and both round-robin pointers are 0. Reset asserted mid-frame abandons the frame; no frame_done_out is emitted.
- FSM states:
  - IDLE: on start_in, latch cam_forward_in, zero the counters, go to SCAN.
  - SCAN: dispatch pixels; after pixel (W-1, H-1) is issued, go to DRAIN.
  - DRAIN: wait until all units are idle, all slots are empty, and the final handshake completes; pulse frame_done_out; go to IDLE.
- start_in in any state other than IDLE is ignored.
- Unit eligibility: a unit is eligible when gen_ready_in[i] = 1, its internal busy[i] = 0, and slot_full[i] = 0.
- Dispatch:
  - busy[i] is set on dispatch. This covers the unit's registered ready drop.
  - busy[i] is cleared when the result is captured.
  - At most one dispatch per cycle. The grant goes to the first eligible unit at or after dispatch_ptr (wrapping); dispatch_ptr then becomes grant+1 mod NUM_UNITS.
  - gen_valid_out, gen_hcount_out and gen_vcount_out are registered. The strobe is high for exactly the cycle after the grant decision, with the coordinates stable in that cycle.
- Raster order: hcount increments 0..W-1; on wrap it returns to 0 and vcount increments. The counter advances only on dispatch.
- Capture: gen_valid_in[i] writes gen_ray_in[i] and the stored tag for unit i into slot i and sets slot_full[i]. A result arriving while the slot is full is impossible by construction; an assertion flags it.
- Output:
  - ray_valid_out is high when any slot is full. The selected slot is the first full slot at or after out_ptr.
  - ray_direction_out and the tag come from the selected slot and are stable while valid is high and ready is low.
  - On a handshake (valid & ready) the slot clears and out_ptr becomes sel+1.
  - Result order is not raster order; consumers use the tag.
- Simultaneous capture into slot i and drain of a different slot j are both honoured in the same cycle.
- A drained slot may be re-dispatched no earlier than the next cycle.
- Minimum latency, start_in to first gen_valid_out: 2 cycles.

Optional Feature:
- RAY_GEN_SCHED_STATS_EN:
  - When defined, adds output stall_cycles_out (32 bits), which counts SCAN cycles in which no unit is eligible, and output frame_cycles_out (32 bits), which holds the IDLE-to-frame_done duration.
  - Both are cleared on start_in and on reset; frame_cycles_out holds its value until the next start.
  - When undefined, neither port exists and no counters are synthesised.

Decomposition:
- Shared package / vector_arith: vec3 and fp types, the FSM state enum (IDLE/SCAN/DRAIN), and a pixel tag struct {hcount, vcount}.
- One natural sub-module, rr_arbiter (parameter N): request vector plus pointer in, one-hot grant and grant index out. It is instantiated twice, once for dispatch and once for output.

Test Plan:
- NUM_UNITS=1, W=4, H=2, ray_ready_in held 1, unit model with latency 5 -> 8 results tagged (0,0)..(3,1) in raster order; frame_done_out pulses once; busy_out falls in the same cycle.
- NUM_UNITS=4, all units ready, model latency 10 -> first four dispatches go to units 0,1,2,3 on consecutive cycles with tags (0,0),(1,0),(2,0),(3,0).
- Units 0 and 2 ready, units 1 and 3 held not-ready -> grants alternate 0,2,0,2; units 1 and 3 never strobed.
- ray_ready_in held 0 for 50 cycles with NUM_UNITS=2 -> exactly 2 dispatches occur, then dispatch stalls; ray_direction_out stays stable; on release, draining resumes with no lost or duplicated tags.
- Two units return results in the same cycle -> both slots captured; outputs appear on consecutive accepted cycles in round-robin order.
- rst_in pulsed mid-SCAN -> all outputs go to 0 immediately; start_in afterwards restarts the frame at tag (0,0).
